// File: rtl/brick_writer.sv
// Writer side of the brick table: builds the brick wall on request and rewrites
// bricks as dead when the collision logic asks for an erase.
module brick_writer #(
    parameter int COL_BITS = 3,
    parameter int ROW_BITS = 2,
    parameter int X0       = 8,
    parameter int Y0       = 10,
    parameter int PITCH_X  = 18,
    parameter int PITCH_Y  = 5
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         init_start,
    input  logic                         erase_req,
    input  logic [ROW_BITS+COL_BITS-1:0] erase_addr,
    output logic                         wr_en,
    output logic [ROW_BITS+COL_BITS-1:0] wr_addr,
    output logic [18:0]                  wr_data,
    output logic                         init_busy,
    output logic                         init_done,
    output logic                         erase_ack,
    output logic [ROW_BITS+COL_BITS:0]   bricks_left,
    output logic                         all_cleared
);

    localparam int AW = ROW_BITS + COL_BITS;
    localparam int N  = 1 << AW;
    localparam logic [AW-1:0] LAST_ADDR = AW'(N - 1);

    typedef enum logic [1:0] {IDLE, INIT, ERASE, ACK} state_t;

    state_t        state;
    logic [AW-1:0] cnt;
    logic [AW-1:0] cnt_nxt;
    logic [AW-1:0] lat_addr;
    logic [N-1:0]  alive;

    assign cnt_nxt = cnt + AW'(1);

    // Record layout {x[7:0], alive, y[6:0], colour[2:0]}; dead bricks keep
    // their position so the display can still place the black rectangle.
    function automatic logic [18:0] record(input logic [AW-1:0] a, input logic live);
        logic [31:0] x;
        logic [31:0] y;
        logic [2:0]  c;
        x = 32'(X0) + 32'(a[COL_BITS-1:0]) * 32'(PITCH_X);
        y = 32'(Y0) + 32'(a[AW-1:COL_BITS]) * 32'(PITCH_Y);
        c = live ? (3'(a[AW-1:COL_BITS]) + 3'd1) : 3'd0;
        return {x[7:0], live, y[6:0], c};
    endfunction

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            cnt         <= '0;
            lat_addr    <= '0;
            alive       <= '0;
            wr_en       <= 1'b0;
            wr_addr     <= '0;
            wr_data     <= '0;
            init_busy   <= 1'b0;
            init_done   <= 1'b0;
            erase_ack   <= 1'b0;
            bricks_left <= '0;
            all_cleared <= 1'b0;
        end else begin
            wr_en     <= 1'b0;
            wr_addr   <= '0;
            wr_data   <= '0;
            init_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (init_start) begin
                        // The first write is issued on the entry edge so the
                        // strobe stays high for exactly N cycles.
                        state       <= INIT;
                        init_busy   <= 1'b1;
                        alive       <= '1;
                        bricks_left <= (AW+1)'(N);
                        all_cleared <= 1'b0;
                        cnt         <= '0;
                        wr_en       <= 1'b1;
                        wr_addr     <= '0;
                        wr_data     <= record('0, 1'b1);
                    end else if (erase_req) begin
                        state    <= ERASE;
                        lat_addr <= erase_addr;
                    end
                end
                INIT: begin
                    if (cnt == LAST_ADDR) begin
                        state     <= IDLE;
                        init_busy <= 1'b0;
                        init_done <= 1'b1;
                    end else begin
                        cnt     <= cnt_nxt;
                        wr_en   <= 1'b1;
                        wr_addr <= cnt_nxt;
                        wr_data <= record(cnt_nxt, 1'b1);
                    end
                end
                ERASE: begin
                    state <= ACK;
                    if (alive[lat_addr]) begin
                        wr_en           <= 1'b1;
                        wr_addr         <= lat_addr;
                        wr_data         <= record(lat_addr, 1'b0);
                        alive[lat_addr] <= 1'b0;
                        if (bricks_left != '0) begin
                            bricks_left <= bricks_left - (AW+1)'(1);
                            if (bricks_left == (AW+1)'(1))
                                all_cleared <= 1'b1;
                        end
                    end
                end
                ACK: begin
                    // Four-phase: ack stays up until the requester drops req.
                    if (!erase_req) begin
                        state     <= IDLE;
                        erase_ack <= 1'b0;
                    end else begin
                        erase_ack <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/brick_writer.md
Name: brick_writer

Overview:
- Writer side of the brick table. The display path reads 19-bit records {x[7:0], alive, y[6:0], colour[2:0]} from this table.
- On `init_start`, fills the table with a ROWS×COLS grid of live bricks, one write per cycle.
- Afterwards, services erase requests from the collision logic with a four-phase handshake. Each erase rewrites the brick as dead/black at the same position.
- Tracks the remaining brick count and flags when the wall is cleared.

Parameters:
- COL_BITS, 3, log2 of columns (COLS = 8)
- ROW_BITS, 2, log2 of rows (ROWS = 4); N = COLS*ROWS = 32
- X0, 8, x pixel of column 0
- Y0, 10, y pixel of row 0
- PITCH_X, 18, x distance between column origins (16-px brick + 2 gap)
- PITCH_Y, 5, y distance between row origins (4-px brick + 1 gap)

Ports:
- clock  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high reset
- init_start  in  1  one-cycle pulse; (re)build the wall
- erase_req  in  1  erase request, held until erase_ack seen
- erase_addr  in  ROW_BITS+COL_BITS  brick index {row,col}, stable while erase_req high
- wr_en  out  1  table write strobe
- wr_addr  out  ROW_BITS+COL_BITS  table address {row,col}
- wr_data  out  19  {x[7:0], alive, y[6:0], colour[2:0]}
- init_busy  out  1  high in INIT
- init_done  out  1  one-cycle pulse after the last init write
- erase_ack  out  1  handshake acknowledge
- bricks_left  out  ROW_BITS+COL_BITS+1  live brick count
- all_cleared  out  1  level; wall emptied by erases

Behaviour:
- Reset: asynchronous, takes effect immediately. All outputs 0, alive bitmap 0, state IDLE. Reset mid-INIT or mid-erase aborts with no further writes.
- All outputs are registered.
- Record fields for {row,col}:
  - x = X0 + col*PITCH_X, truncated to 8 bits.
  - y = Y0 + row*PITCH_Y, truncated to 7 bits.
  - Live brick: alive = 1, colour = row+1 (3 bits).
  - Erased brick: alive = 0, colour = 0, same x,y.
- FSM states: IDLE, INIT, ERASE, ACK.
- IDLE:
  - `init_start` → INIT, with priority over `erase_req`.
  - Else `erase_req` → ERASE; `erase_addr` is latched on this edge.
- INIT:
  - Address counter runs 0..N-1. One write per cycle, wr_en=1 for exactly N consecutive cycles, addresses in ascending order.
  - On entry: bitmap all 1, bricks_left = N, all_cleared = 0.
  - After the write of N-1: return to IDLE, and init_done = 1 for one cycle (the cycle after the last wr_en).
  - `init_start` and `erase_req` are ignored during INIT; a held request is served afterwards.
- ERASE (one cycle, then ACK):
  - Latched brick alive: wr_en=1 with the erased record, bit cleared, bricks_left decremented. If bricks_left becomes 0, all_cleared = 1.
  - Brick already dead: no write, no count change.
- ACK:
  - erase_ack = 1, held until `erase_req` is sampled low; then IDLE with erase_ack = 0.
  - `init_start` is ignored in ERASE/ACK.
- Latency: erase_req sampled high at edge k → wr_en high cycle k+1 → erase_ack high from cycle k+2.
- Before any init, the bitmap is 0, so erases are acked with no write.
- bricks_left never underflows.
- all_cleared is cleared only by reset or by entering INIT.
- wr_data and wr_addr are 0 whenever wr_en = 0.

Test Plan:
- Reset, pulse init_start → wr_en high 32 cycles. Addr 0 data {8'd8,1,7'd10,3'd1}. Addr 31 (row3,col7) data {8'd134,1,7'd25,3'd4}. init_done pulses once, bricks_left = 32.
- After init, erase addr 5'b01_010 → one write {8'd44,0,7'd15,3'd0} at addr 10. erase_ack held until req drops. bricks_left = 31.
- Erase addr 10 again → ack, no wr_en, bricks_left stays 31.
- Erase all 32 bricks → all_cleared rises on the 32nd write. A new init_start clears it and restores bricks_left = 32.
- erase_req raised during INIT and init_start raised in ACK → erase served only after init_done; the init pulse in ACK produces no writes.
- Assert reset at init write 12 → wr_en, init_busy and bricks_left go 0 immediately. After release, state is IDLE and no writes occur until init_start.
